// File: rtl/fir_transpose_param.sv
// Transposed-form FIR filter with runtime-writable coefficients, valid-qualified
// input, stall tolerance, synchronous flush and saturating scaled output.
module fir_transpose_param #(
    parameter int TAPS  = 8,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 24,
    parameter int SHIFT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]      coef_wdata,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic signed [DW-1:0]      din,
    output logic                      out_valid,
    output logic signed [OW-1:0]      dout,
    output logic                      ovf
);

    localparam int AB = $clog2(TAPS);
    localparam int AW = DW + CW + AB;
    // One bit wider than both accumulator and output so range checks never wrap
    localparam int EW = ((AW > OW) ? AW : OW) + 1;
    localparam logic signed [AW-1:0] ZERO_ACC = '0;

    logic signed [CW-1:0] c_q   [TAPS];
    logic signed [AW-1:0] s_q   [TAPS-1];
    logic signed [AW-1:0] s_d   [TAPS-1];

    logic signed [AW-1:0] x_ext_p0;
    logic signed [AW-1:0] c_ext_p0;
    logic signed [AW-1:0] prod_p0 [TAPS];
    logic signed [AW-1:0] hist_p0 [TAPS-1];
    logic signed [AW-1:0] y_p0;
    logic        [OW:0]   sat_p0;
    logic                 addr_ok;

    logic                 vld_p1_q;
    logic signed [OW-1:0] dout_p1_q;
    logic                 ovf_p1_q;

    // Arithmetic shift then clamp into OW bits; returns {ovf, value}.
    function automatic logic [OW:0] sat_scale(input logic signed [AW-1:0] y);
        logic signed [AW-1:0] r;
        logic signed [EW-1:0] re;
        logic signed [EW-1:0] maxv;
        logic signed [EW-1:0] minv;
        logic [OW:0]          res;
        r    = y >>> SHIFT;
        re   = {{(EW-AW){r[AW-1]}}, r};
        maxv = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
        minv = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};
        if (re > maxv) begin
            res = {1'b1, maxv[OW-1:0]};
        end else if (re < minv) begin
            res = {1'b1, minv[OW-1:0]};
        end else begin
            res = {1'b0, re[OW-1:0]};
        end
        return res;
    endfunction

    // Stage p0: broadcast sample times every coefficient, add the chain
    always_comb begin
        x_ext_p0 = {{(AW-DW){din[DW-1]}}, din};
        c_ext_p0 = ZERO_ACC;
        for (int k = 0; k < TAPS; k++) begin
            c_ext_p0   = {{(AW-CW){c_q[k][CW-1]}}, c_q[k]};
            prod_p0[k] = c_ext_p0 * x_ext_p0;
        end
        for (int k = 0; k < TAPS-1; k++) begin
            hist_p0[k] = flush ? ZERO_ACC : s_q[k];
        end
        y_p0 = prod_p0[0] + hist_p0[0];
        for (int k = 0; k < TAPS-2; k++) begin
            s_d[k] = prod_p0[k+1] + hist_p0[k+1];
        end
        s_d[TAPS-2] = prod_p0[TAPS-1];
        sat_p0  = sat_scale(y_p0);
        addr_ok = (32'(coef_addr) < TAPS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                c_q[k] <= '0;
            end
            for (int k = 0; k < TAPS-1; k++) begin
                s_q[k] <= '0;
            end
            vld_p1_q  <= 1'b0;
            dout_p1_q <= '0;
            ovf_p1_q  <= 1'b0;
        end else begin
            vld_p1_q <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < TAPS-1; k++) begin
                    s_q[k] <= s_d[k];
                end
                ovf_p1_q  <= sat_p0[OW];
                dout_p1_q <= sat_p0[OW-1:0];
            end else if (flush) begin
                for (int k = 0; k < TAPS-1; k++) begin
                    s_q[k] <= '0;
                end
            end
            // Same-edge sample already used the old bank above
            if (coef_we && addr_ok) begin
                c_q[coef_addr] <= coef_wdata;
            end
        end
    end

    // Stage p1: registered outputs
    assign out_valid = vld_p1_q;
    assign dout      = dout_p1_q;
    assign ovf       = ovf_p1_q;

endmodule

// File: tb/tb_fir_transpose_param.sv
// Bench for fir_transpose_param: two instances (SHIFT=0 and SHIFT=8) share one
// stimulus stream and are compared against a sample-history convolution model.
module tb_fir_transpose_param;

    localparam int TAPS = 8;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int OW   = 24;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   coef_we;
    logic [2:0]             coef_addr;
    logic signed [CW-1:0]   coef_wdata;
    logic                   flush;
    logic                   in_valid;
    logic signed [DW-1:0]   din;
    logic                   out_valid0, out_valid1;
    logic signed [OW-1:0]   dout0, dout1;
    logic                   ovf0, ovf1;

    int errors = 0;
    int checks = 0;
    string phase = "init";

    // Model: coefficient bank plus the recent accepted samples, each with the
    // coefficient bank that was live when it was accepted.
    longint mc [TAPS];
    longint hx [TAPS];
    longint hc [TAPS][TAPS];
    int     hn;
    bit     ev;
    longint ed0, ed1;
    bit     eo0, eo1;

    fir_transpose_param #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(0)) u0 (
        .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .flush(flush), .in_valid(in_valid), .din(din),
        .out_valid(out_valid0), .dout(dout0), .ovf(ovf0)
    );

    fir_transpose_param #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(8)) u1 (
        .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .flush(flush), .in_valid(in_valid), .din(din),
        .out_valid(out_valid1), .dout(dout1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    function automatic longint msat(input longint y, input int sh, output bit o);
        longint r;
        longint mx;
        longint mn;
        r  = y >>> sh;
        mx = (longint'(1) <<< (OW-1)) - 1;
        mn = -(longint'(1) <<< (OW-1));
        o  = 1'b1;
        if (r > mx) return mx;
        if (r < mn) return mn;
        o = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) mc[k] = 0;
        hn  = 0;
        ev  = 1'b0;
        ed0 = 0; ed1 = 0;
        eo0 = 1'b0; eo1 = 1'b0;
    endtask

    task automatic model_edge(input bit we, input int addr, input longint wd,
                              input bit fl, input bit iv, input longint x);
        longint y;
        if (fl) hn = 0;
        if (iv) begin
            for (int j = TAPS-1; j > 0; j--) begin
                hx[j] = hx[j-1];
                for (int k = 0; k < TAPS; k++) hc[j][k] = hc[j-1][k];
            end
            hx[0] = x;
            for (int k = 0; k < TAPS; k++) hc[0][k] = mc[k];
            if (hn < TAPS) hn++;
            y = 0;
            for (int j = 0; j < hn; j++) y += hc[j][j] * hx[j];
            ed0 = msat(y, 0, eo0);
            ed1 = msat(y, 8, eo1);
        end
        ev = iv;
        if (we && addr < TAPS) mc[addr] = wd;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid0", out_valid0, ev);
        chk("dout0", dout0, ed0);
        chk("ovf0", ovf0, eo0);
        chk("out_valid1", out_valid1, ev);
        chk("dout1", dout1, ed1);
        chk("ovf1", ovf1, eo1);
    endtask

    task automatic step(input bit we, input int addr, input longint wd,
                        input bit fl, input bit iv, input longint x);
        logic [31:0] a;
        logic [63:0] w;
        logic [63:0] xv;
        @(negedge clk);
        a  = addr;
        w  = wd;
        xv = x;
        coef_we    = we;
        coef_addr  = a[2:0];
        coef_wdata = w[CW-1:0];
        flush      = fl;
        in_valid   = iv;
        din        = xv[DW-1:0];
        @(posedge clk);
        model_edge(we, addr, wd, fl, iv, x);
        #1;
        check_outputs();
    endtask

    task automatic write_all(input longint v);
        for (int k = 0; k < TAPS; k++) step(1'b1, k, v, 1'b0, 1'b0, 0);
    endtask

    initial begin
        reset = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        flush = 1'b0; in_valid = 1'b0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        phase = "reset";
        check_outputs();
        @(negedge clk);
        reset = 1'b1;

        phase = "impulse";
        for (int k = 0; k < TAPS; k++) step(1'b1, k, k + 1, 1'b0, 1'b0, 0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 1);
        for (int i = 0; i < TAPS; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 0);

        phase = "stall";
        for (int i = 0; i < TAPS + 1; i++) begin
            step(1'b0, 0, 0, 1'b0, 1'b1, (i == 0) ? 1 : 0);
            repeat (3) step(1'b0, 0, 0, 1'b0, 1'b0, 0);
        end

        phase = "sat_pos";
        write_all(32767);
        for (int i = 0; i < TAPS; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 32767);
        phase = "sat_neg";
        for (int i = 0; i < TAPS; i++) step(1'b0, 0, 0, 1'b0, 1'b1, -32768);

        phase = "scale";
        write_all(0);
        step(1'b1, 0, 256, 1'b0, 1'b0, 0);
        step(1'b0, 0, 0, 1'b1, 1'b1, -3);
        step(1'b0, 0, 0, 1'b0, 1'b1, -3);
        step(1'b1, 0, 1, 1'b1, 1'b0, 0);
        step(1'b0, 0, 0, 1'b0, 1'b1, -1);
        step(1'b0, 0, 0, 1'b0, 1'b1, -1);

        phase = "coef_update";
        write_all(1);
        step(1'b0, 0, 0, 1'b1, 1'b1, 2);
        for (int i = 0; i < TAPS; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 2);
        step(1'b1, 0, 5, 1'b0, 1'b1, 2);
        step(1'b0, 0, 0, 1'b0, 1'b1, 2);

        phase = "flush";
        step(1'b1, 0, 1, 1'b0, 1'b0, 0);
        for (int i = 0; i < TAPS; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 2);
        step(1'b0, 0, 0, 1'b1, 1'b1, 2);
        for (int i = 0; i < TAPS; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 2);
        step(1'b0, 0, 0, 1'b1, 1'b0, 0);
        step(1'b0, 0, 0, 1'b0, 1'b1, 3);

        phase = "flush_we_same_edge";
        step(1'b1, 3, 9, 1'b1, 1'b1, 4);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 1);

        phase = "async_reset";
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0, 1'b1, 2);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            bit     we, fl, iv;
            int     addr;
            longint wd, x;
            we   = ($urandom_range(9) == 0);
            fl   = ($urandom_range(19) == 0);
            iv   = ($urandom_range(9) < 7);
            addr = $urandom_range(TAPS - 1);
            wd   = ($urandom_range(1) == 0) ? longint'($urandom_range(65535)) - 32768
                                            : longint'($urandom_range(15)) - 8;
            x    = ($urandom_range(1) == 0) ? longint'($urandom_range(65535)) - 32768
                                            : longint'($urandom_range(255)) - 128;
            step(we, addr, wd, fl, iv, x);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_transpose_param.md
Name: fir_transpose_param

Overview:
- Parametrised transposed-form FIR filter. It generalises the fixed 5-tap integer transpose filter to TAPS taps, fixed-width signed data, and runtime-writable coefficients.
- Adds a valid-qualified data path, stall tolerance, synchronous flush, output scaling with saturation, and an overflow flag.
- Sits in the lab DSP chain between the sample source and the downstream sink. One sample is accepted per valid cycle.

Parameters:
- TAPS, 8, number of coefficients (filter order = TAPS-1); legal range 2..64
- DW, 16, signed input sample width
- CW, 16, signed coefficient width
- OW, 24, signed output width
- SHIFT, 0, arithmetic right shift applied to the full-precision result before saturation; legal range 0..DW+CW-1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  coefficient index to write
- coef_wdata  in  CW  signed coefficient value
- flush  in  1  synchronous clear of the partial-sum chain
- in_valid  in  1  din is valid this cycle
- din  in  DW  signed input sample
- out_valid  out  1  dout is valid this cycle
- dout  out  OW  signed filtered sample
- ovf  out  1  saturation occurred on this dout; meaningful only when out_valid=1

Behaviour:
- Full precision: AW = DW+CW+$clog2(TAPS). All products and partial sums are signed and AW wide, with no internal wrap.
- State:
  - coefficient bank c[0..TAPS-1] (CW each)
  - partial-sum registers s[0..TAPS-2] (AW each)
  - output registers dout, out_valid, ovf
- Reset (reset=0, asynchronous):
  - all c[k]=0 and all s[k]=0
  - dout=0, out_valid=0, ovf=0
  - Takes effect immediately, mid-stream included. The first valid sample after release sees an all-zero history.
- Filter step, on a rising edge with in_valid=1, where x=din:
  - y = c[0]*x + s[0]
  - s[k] <= c[k+1]*x + s[k+1] for k=0..TAPS-3
  - s[TAPS-2] <= c[TAPS-1]*x
- Stall: when in_valid=0, s[] holds and out_valid<=0. dout and ovf hold their last values. Gaps between samples therefore do not change the impulse response.
- Latency: dout and out_valid are registered and appear 1 cycle after the accepting edge. Throughput is 1 sample/cycle.
- Output scaling:
  - r = y >>> SHIFT (arithmetic shift, truncation toward -inf)
  - If r > 2^(OW-1)-1: dout = 2^(OW-1)-1 and ovf=1.
  - If r < -2^(OW-1): dout = -2^(OW-1) and ovf=1.
  - Otherwise dout = r[OW-1:0] and ovf=0.
  - ovf is registered alongside dout.
- Coefficient write: on an edge with coef_we=1, c[coef_addr] <= coef_wdata.
  - A sample accepted on the same edge uses the old coefficient values.
  - The new value applies from the next accepted sample.
  - Existing s[] contents are not recomputed, so the transition is a mixed response by design.
  - coef_addr >= TAPS: the write is ignored.
- Flush: on an edge with flush=1, s[] is treated as all-zero.
  - With in_valid=0: s[k] <= 0; out_valid<=0.
  - With in_valid=1: y = c[0]*x; s[k] <= c[k+1]*x for k=0..TAPS-3; s[TAPS-2] <= c[TAPS-1]*x. The sample becomes the first of a fresh stream, and out_valid<=1 next cycle.
  - Flush does not alter c[].
- Simultaneous coef_we, flush and in_valid: flush semantics apply, using the old coefficients. The write lands on the same edge.

Test Plan:
- Impulse: TAPS=8, SHIFT=0, write c[k]=k+1, then din=1 followed by seven 0s (all in_valid=1) -> dout=1,2,3,4,5,6,7,8, then 0; out_valid high one cycle after each accept; ovf=0.
- Stall: same coefficients, impulse with in_valid=0 for 3 cycles between every valid sample -> identical dout sequence 1..8; out_valid low during gaps.
- Saturation: OW=24, all c[k]=32767, din=32767 held for 8 valid cycles -> sums exceed 8388607, so dout=8388607 with ovf=1. With din=-32768 -> dout=-8388608 with ovf=1.
- Scaling: c[0]=256, others 0, SHIFT=8, din=-3 -> dout=-3, ovf=0. With din=-1 and c[0]=1 -> dout=-1 (truncation toward -inf).
- Coefficient update mid-stream: c[k]=1 for all k, DC din=2 steady gives dout=16. Write c[0]=5 on the same edge as an accept -> that output is still 16; the next output is 24.
- Flush / reset: during steady DC output 16, flush=1 with in_valid=1, din=2 -> dout=2, then 4, 6, … 16. Asserting reset low mid-stream -> dout=0 and out_valid=0 immediately, and c[] clears, so subsequent outputs are 0 until coefficients are rewritten.
